// File: rtl/vertex_buffer_multi_pkg.sv
// rtl/vertex_buffer_multi_pkg.sv - shared widths, defaults and entry type for the vertex output buffer
`ifndef Num_Vertex_Unit
`define Num_Vertex_Unit 4
`endif

package vertex_buffer_multi_pkg;

  localparam int VB_NUM_CH = `Num_Vertex_Unit;
  localparam int VB_DEPTH  = 8;
  localparam int VB_VID_W  = 10;
  localparam int VB_DATA_W = 16;

  typedef struct packed {
    logic [VB_VID_W-1:0]  vid;
    logic [VB_DATA_W-1:0] data;
  } vb_entry_t;

endpackage

// File: rtl/vertex_buffer_chan.sv
// rtl/vertex_buffer_chan.sv - one channel FIFO with tail merging and flush draining
module vertex_buffer_chan
  import vertex_buffer_multi_pkg::*;
#(
  parameter int DEPTH  = VB_DEPTH,
  parameter int DATA_W = VB_DATA_W,
  parameter int VID_W  = VB_VID_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [VID_W-1:0]  in_vid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              mode_accum,
  input  logic              flush,
  input  logic              req_grant,
  output logic              out_req,
  output logic [VID_W-1:0]  out_vid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [VID_W-1:0]  vid_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             flush_pend;
  logic             nonempty;
  logic             pop;
  logic             wr_acc;
  logic             merge;
  logic             push;

  assign nonempty = (count != '0);
  assign tail_ptr = wr_ptr - PTR_W'(1);
  assign in_ready = (count != FULL_CNT);
  assign busy     = nonempty;
  assign out_vid  = vid_mem[rd_ptr];
  assign out_data = data_mem[rd_ptr];

  // In accumulate mode a lone tail stays open for merges unless a flush is pending.
  assign out_req = mode_accum ? ((count > ONE_CNT) | ((count == ONE_CNT) & flush_pend))
                              : nonempty;

  assign pop    = out_req & req_grant;
  assign wr_acc = in_valid & in_ready;
  // A tail being popped this cycle cannot absorb a merge; the write starts a new entry.
  assign merge  = wr_acc & mode_accum & nonempty & (in_vid == vid_mem[tail_ptr])
                & ~((count == ONE_CNT) & pop);
  assign push   = wr_acc & ~merge;

  always_comb begin
    count_nxt = count;
    if (push & ~pop) begin
      count_nxt = count + ONE_CNT;
    end else if (pop & ~push) begin
      count_nxt = count - ONE_CNT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      if (count_nxt == '0) begin
        flush_pend <= 1'b0;
      end else if (flush & nonempty) begin
        flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      vid_mem[wr_ptr]  <= in_vid;
      data_mem[wr_ptr] <= in_data;
    end else if (merge) begin
      data_mem[tail_ptr] <= data_mem[tail_ptr] + in_data;
    end
  end

endmodule

// File: rtl/vertex_buffer_multi.sv
// rtl/vertex_buffer_multi.sv - NUM_CH vertex output buffer channels with a global drain flag
module vertex_buffer_multi
  import vertex_buffer_multi_pkg::*;
#(
  parameter int NUM_CH = VB_NUM_CH,
  parameter int DEPTH  = VB_DEPTH,
  parameter int DATA_W = VB_DATA_W,
  parameter int VID_W  = VB_VID_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*VID_W-1:0]  in_vid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode_accum,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        req_grant,
  output logic [NUM_CH-1:0]        out_req,
  output logic [NUM_CH*VID_W-1:0]  out_vid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     empty
);

  logic [NUM_CH-1:0] ch_busy;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    vertex_buffer_chan #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .VID_W  (VID_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[i]),
      .in_vid     (in_vid[i*VID_W +: VID_W]),
      .in_data    (in_data[i*DATA_W +: DATA_W]),
      .in_ready   (in_ready[i]),
      .mode_accum (mode_accum),
      .flush      (flush),
      .req_grant  (req_grant[i]),
      .out_req    (out_req[i]),
      .out_vid    (out_vid[i*VID_W +: VID_W]),
      .out_data   (out_data[i*DATA_W +: DATA_W]),
      .busy       (ch_busy[i])
    );
  end

  assign busy  = |ch_busy;
  assign empty = ~busy;

endmodule
